boot_frame_loader: RTL and testbench
====================================

# boot_frame_loader

Framed UART boot loader sitting between the programming UART receiver and the instruction RAM write port. Consumes received bytes (`rx_dv_i`/`rx_byte_i`), parses a sync/length/address header, assembles little-endian 32-bit words and issues one RAM write per word. Validates a trailing checksum and holds the core in reset until a valid frame has been loaded.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word-address width.
- `MAX_WORDS`, 256: largest accepted frame length in words.
- `TIMEOUT_CYC`, 65535: idle cycles allowed between bytes inside a frame.

Ports:
- `clk_i` in 1: sole clock.
- `rst_i` in 1: reset; synchronous and active-high (already decided).
- `rx_dv_i` in 1: byte-valid strobe from UART receiver; one byte per asserted cycle.
- `rx_byte_i` in 8: received byte; sampled only when `rx_dv_i`=1.
- `we_o` out 1: one-cycle RAM write strobe.
- `addr_o` out ADDR_W: RAM word address, valid with `we_o`.
- `wdata_o` out 32: RAM write data, valid with `we_o`.
- `core_rst_no` out 1: 0 holds the core in reset; 1 releases it.
- `busy_o` out 1: 1 while a frame is in progress (any state except IDLE and RUN).
- `done_o` out 1: 1 once a frame has passed its checksum.
- `err_o` out 1: sticky error flag.
- `err_code_o` out 2: 00 none, 01 bad length/range, 10 checksum, 11 timeout.

## Operation
- Frame layout: `0xA5`, LEN_LO, LEN_HI, ADR_LO, ADR_HI, then 4·LEN data bytes (LSB first per word), then CSUM.
- FSM states: IDLE, LEN_LO, LEN_HI, ADR_LO, ADR_HI, DATA, CSUM, RUN. Each accepted byte advances by one state, except DATA, which stays until 4·LEN bytes are taken.
- IDLE: non-`0xA5` bytes are ignored. `0xA5` clears `err_o`/`err_code_o`, clears the checksum accumulator and goes to LEN_LO.
- Checksum: an 8-bit accumulator, summed mod 256 over every byte after sync, including CSUM. The frame is good iff the final sum is 0x00.
- On ADR_HI accept, the header is checked. If LEN=0, LEN>MAX_WORDS, or base+LEN > 2^ADDR_W, the block raises err 01 and returns to IDLE; no write occurs.
- DATA: bytes are shifted into a 32-bit register, first byte in [7:0]. On the 4th byte of each word, `we_o` pulses with `addr_o` = base + word index (ADDR_W-bit arithmetic) and `wdata_o` = the assembled word. After LEN words the FSM goes to CSUM.
- CSUM accept:
  - Sum 0: go to RUN; `done_o`=1 and `core_rst_no`=1.
  - Sum ≠0: err 10; return to IDLE. RAM writes already made are not undone.
- RUN is terminal. All bytes are ignored until `rst_i`.
- Timeout: a counter clears on every `rx_dv_i` and increments in LEN_LO..CSUM. Reaching TIMEOUT_CYC raises err 11 and returns to IDLE.
- Errors never release the core. `core_rst_no` stays 0 until RUN.

## Timing
- Reset values: state IDLE, `we_o`=0, `addr_o`=0, `wdata_o`=0, `core_rst_no`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `err_code_o`=00. The counter and accumulator are also cleared.
- All outputs are registered.
- `we_o`/`addr_o`/`wdata_o` are valid in the cycle after the 4th byte's `rx_dv_i` cycle.
- `done_o`/`core_rst_no` rise, or error flags set, in the cycle after the CSUM `rx_dv_i` cycle.
- Header error flags appear in the cycle after the ADR_HI `rx_dv_i` cycle.
- `rx_dv_i` may be asserted on consecutive cycles; every asserted cycle is consumed with no backpressure.
- Timeout fires in the cycle the counter equals TIMEOUT_CYC. If `rx_dv_i` is asserted in that same cycle, the byte wins and the counter clears.
- `rst_i` mid-frame aborts immediately. A partial word is never written.

## Test plan
- Good frame: A5 02 00 10 00 EF BE AD DE 67 45 23 01 E6 -> `we_o` at addr 0x010 with 0xDEADBEEF, then at addr 0x011 with 0x01234567. Next cycle after E6: `done_o`=1, `core_rst_no`=1, `err_o`=0.
- Same frame with CSUM E7 -> both writes occur; `err_code_o`=10, `core_rst_no`=0, state IDLE. A following good frame then completes normally.
- Header checks -> A5 00 00 00 00 gives err 01 with no `we_o`. A5 02 00 FF 3F (base 0x3FFF, ADDR_W=14) gives err 01 with no `we_o`.
- TIMEOUT_CYC=100, frame stops after 3 data bytes -> err 11 exactly 100 cycles after the last byte; no `we_o`. The next A5 clears `err_o`.
- Noise and RUN lockout -> 00 FF 5A before sync are ignored and the good frame loads. Bytes (including A5) after RUN cause no writes and no state change.
- Back-to-back `rx_dv_i` every cycle for the good frame -> identical writes. `rst_i` asserted after 2 data bytes -> all outputs at reset values and no `we_o`.

Source files
------------

// File: rtl/boot_frame_loader.sv
// Framed UART boot loader: parses sync/length/address header, writes little-endian
// 32-bit words to instruction RAM and releases the core after a good checksum.
module boot_frame_loader #(
  parameter int ADDR_W      = 14,
  parameter int MAX_WORDS   = 256,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_ADR_LO, S_ADR_HI, S_DATA, S_CSUM, S_RUN
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [7:0]        adr_lo_reg, adr_lo_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [15:0]       word_idx_reg, word_idx_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       data_reg, data_next;
  logic [7:0]        csum_reg, csum_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [1:0]        err_code_reg, err_code_next;

  logic [15:0] hdr_addr;
  logic [31:0] hdr_end;
  logic        hdr_bad;
  logic [7:0]  csum_sum;
  logic [31:0] data_shift;
  logic        in_frame;
  logic        tmo_fire;

  // Header is judged on the ADR_HI byte itself, so the high address byte comes straight from the input.
  assign hdr_addr   = {rx_byte_i, adr_lo_reg};
  assign hdr_end    = {16'd0, hdr_addr} + {16'd0, len_reg};
  assign hdr_bad    = (len_reg == 16'd0) || ({16'd0, len_reg} > 32'(MAX_WORDS))
                      || (hdr_end > (32'd1 << ADDR_W));
  assign csum_sum   = csum_reg + rx_byte_i;
  assign data_shift = {rx_byte_i, data_reg[31:8]};
  assign in_frame   = (state_reg != S_IDLE) && (state_reg != S_RUN);
  // tmo_reg counts completed idle cycles; this cycle is idle cycle number tmo_reg+1.
  assign tmo_fire   = in_frame && !rx_dv_i && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      adr_lo_reg   <= '0;
      base_reg     <= '0;
      word_idx_reg <= '0;
      byte_cnt_reg <= '0;
      data_reg     <= '0;
      csum_reg     <= '0;
      tmo_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      adr_lo_reg   <= adr_lo_next;
      base_reg     <= base_next;
      word_idx_reg <= word_idx_next;
      byte_cnt_reg <= byte_cnt_next;
      data_reg     <= data_next;
      csum_reg     <= csum_next;
      tmo_reg      <= tmo_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    adr_lo_next   = adr_lo_reg;
    base_next     = base_reg;
    word_idx_next = word_idx_reg;
    byte_cnt_next = byte_cnt_reg;
    data_next     = data_reg;
    csum_next     = csum_reg;
    tmo_next      = '0;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    done_next     = done_reg;
    err_next      = err_reg;
    err_code_next = err_code_reg;

    if (rx_dv_i) begin
      case (state_reg)
        S_IDLE: begin
          if (rx_byte_i == 8'hA5) begin
            err_next      = 1'b0;
            err_code_next = 2'b00;
            csum_next     = 8'd0;
            state_next    = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          len_next[7:0] = rx_byte_i;
          csum_next     = csum_sum;
          state_next    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_next[15:8] = rx_byte_i;
          csum_next      = csum_sum;
          state_next     = S_ADR_LO;
        end
        S_ADR_LO: begin
          adr_lo_next = rx_byte_i;
          csum_next   = csum_sum;
          state_next  = S_ADR_HI;
        end
        S_ADR_HI: begin
          csum_next = csum_sum;
          if (hdr_bad) begin
            err_next      = 1'b1;
            err_code_next = 2'b01;
            state_next    = S_IDLE;
          end else begin
            base_next     = ADDR_W'(hdr_addr);
            word_idx_next = '0;
            byte_cnt_next = '0;
            state_next    = S_DATA;
          end
        end
        S_DATA: begin
          csum_next     = csum_sum;
          data_next     = data_shift;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            we_next       = 1'b1;
            addr_next     = base_reg + ADDR_W'(word_idx_reg);
            wdata_next    = data_shift;
            word_idx_next = word_idx_reg + 16'd1;
            if (word_idx_reg == len_reg - 16'd1) state_next = S_CSUM;
          end
        end
        S_CSUM: begin
          csum_next = csum_sum;
          if (csum_sum == 8'd0) begin
            done_next  = 1'b1;
            state_next = S_RUN;
          end else begin
            err_next      = 1'b1;
            err_code_next = 2'b10;
            state_next    = S_IDLE;
          end
        end
        default: ;
      endcase
    end else if (tmo_fire) begin
      err_next      = 1'b1;
      err_code_next = 2'b11;
      state_next    = S_IDLE;
    end else if (in_frame) begin
      tmo_next = tmo_reg + TMO_W'(1);
    end

    busy_next = (state_next != S_IDLE) && (state_next != S_RUN);
  end

  assign we_o        = we_reg;
  assign addr_o      = addr_reg;
  assign wdata_o     = wdata_reg;
  assign core_rst_no = done_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign err_code_o  = err_code_reg;

endmodule

// File: tb/tb_boot_frame_loader.sv
// Bench for boot_frame_loader: frame-position reference model checked every cycle,
// directed frames from the test plan and randomized frame streams.
module tb_boot_frame_loader;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 256;
  localparam int TMO       = 100;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  boot_frame_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .we_o(we), .addr_o(addr), .wdata_o(wdata), .core_rst_no(core_rst_n),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [63:0] wlog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: tracks the frame as a byte queue and decides by position in the frame.
  logic [7:0]        m_q[$];
  bit                m_in_frame, m_locked, m_done, m_err, m_we;
  logic [1:0]        m_code;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  int                m_idle, m_len, m_base, m_n, m_sum;

  always @(posedge clk) begin : ref_model
    m_we = 1'b0;
    if (rst) begin
      m_q.delete();
      m_in_frame = 0; m_locked = 0; m_done = 0; m_err = 0; m_code = 2'b00; m_idle = 0;
    end else if (!m_locked) begin
      if (rx_dv) begin
        m_idle = 0;
        if (!m_in_frame) begin
          if (rx_byte == 8'hA5) begin
            m_in_frame = 1; m_q.delete(); m_q.push_back(rx_byte);
            m_err = 0; m_code = 2'b00;
          end
        end else begin
          m_q.push_back(rx_byte);
          m_n = m_q.size();
          if (m_n == 5) begin
            m_len  = int'(m_q[1]) + 256 * int'(m_q[2]);
            m_base = int'(m_q[3]) + 256 * int'(m_q[4]);
            if (m_len == 0 || m_len > MAX_WORDS || m_base + m_len > (1 << ADDR_W)) begin
              m_err = 1; m_code = 2'b01; m_in_frame = 0;
            end
          end else if (m_n > 5 && m_n <= 5 + 4 * m_len) begin
            if ((m_n - 5) % 4 == 0) begin
              m_we    = 1'b1;
              m_addr  = ADDR_W'(m_base + (m_n - 5) / 4 - 1);
              m_wdata = {m_q[m_n-1], m_q[m_n-2], m_q[m_n-3], m_q[m_n-4]};
            end
          end else if (m_n == 6 + 4 * m_len) begin
            m_sum = 0;
            for (int i = 1; i < m_n; i++) m_sum += int'(m_q[i]);
            if (m_sum % 256 == 0) begin
              m_done = 1; m_locked = 1;
            end else begin
              m_err = 1; m_code = 2'b10;
            end
            m_in_frame = 0;
          end
        end
      end else if (m_in_frame) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_err = 1; m_code = 2'b11; m_in_frame = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("we", 64'(we), 64'(m_we));
      if (m_we) begin
        check("addr", 64'(addr), 64'(m_addr));
        check("wdata", 64'(wdata), 64'(m_wdata));
      end
      check("done", 64'(done), 64'(m_done));
      check("core_rst_n", 64'(core_rst_n), 64'(m_done));
      check("err", 64'(err), 64'(m_err));
      check("err_code", 64'(err_code), 64'(m_code));
      check("busy", 64'(busy), 64'(m_in_frame));
      if (we === 1'b1) begin
        wlog.push_back(64'({addr, wdata}));
        $display("write addr=%h data=%h t=%0t", addr, wdata, $time);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_byte = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_q(input bq_t f, input int count, input int gap_min, input int gap_max);
    for (int i = 0; i < count && i < f.size(); i++)
      send_byte(f[i], int'($urandom_range(gap_max, gap_min)));
  endtask

  task automatic do_reset;
    rst = 1'b1; rx_dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wlog.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bq_t make_frame(input int len, input int base, input bit bad);
    bq_t f;
    logic [7:0] s, c;
    f.push_back(8'hA5);
    f.push_back(8'(len)); f.push_back(8'(len >> 8));
    f.push_back(8'(base)); f.push_back(8'(base >> 8));
    for (int i = 0; i < 4 * len; i++) f.push_back(8'($urandom));
    s = 8'd0;
    for (int i = 1; i < f.size(); i++) s = s + f[i];
    c = 8'd0 - s;
    if (bad) c = c + 8'd1;
    f.push_back(c);
    return f;
  endfunction

  bq_t good_f, bad_f, hdr0_f, hdr1_f, noise_f, tr_f, rf;
  int  k, len, base, kind;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    good_f  = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                8'h67, 8'h45, 8'h23, 8'h01, 8'hE6};
    hdr0_f  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    hdr1_f  = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'h3F};
    noise_f = '{8'h00, 8'hFF, 8'h5A};
    tr_f    = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    bad_f   = good_f;
    bad_f[13] = 8'hE7;

    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_core", 64'(core_rst_n), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_code", 64'(err_code), 64'd0);
    rst = 1'b0;

    // Good frame with one idle cycle between bytes.
    send_q(good_f, good_f.size(), 1, 1);
    check("good_done", 64'(done), 64'd1);
    check("good_core", 64'(core_rst_n), 64'd1);
    check("good_err", 64'(err), 64'd0);
    check("good_nwr", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("good_w0", wlog[0], {18'd0, 14'h010, 32'hDEADBEEF});
      check("good_w1", wlog[1], {18'd0, 14'h011, 32'h01234567});
    end
    check("model_good_done", 64'(m_done), 64'd1);

    // Bad checksum: writes stay, error 10, then a good frame loads.
    do_reset();
    send_q(bad_f, bad_f.size(), 0, 2);
    check("csum_code", 64'(err_code), 64'd2);
    check("csum_core", 64'(core_rst_n), 64'd0);
    check("csum_busy", 64'(busy), 64'd0);
    check("csum_nwr", 64'(wlog.size()), 64'd2);
    check("model_csum_code", 64'(m_code), 64'd2);
    send_q(good_f, good_f.size(), 0, 0);
    check("csum_retry_done", 64'(done), 64'd1);
    check("csum_retry_err", 64'(err), 64'd0);

    // Header range checks.
    do_reset();
    send_q(hdr0_f, hdr0_f.size(), 0, 1);
    check("hdr0_code", 64'(err_code), 64'd1);
    check("model_hdr0_code", 64'(m_code), 64'd1);
    send_q(hdr1_f, hdr1_f.size(), 0, 1);
    check("hdr1_code", 64'(err_code), 64'd1);
    check("model_hdr1_code", 64'(m_code), 64'd1);
    idle(3);
    check("hdr_nwr", 64'(wlog.size()), 64'd0);

    // Timeout after 3 data bytes.
    do_reset();
    send_q(tr_f, tr_f.size(), 0, 0);
    k = 0;
    while (k < 300) begin
      @(posedge clk); #1;
      k++;
      if (err === 1'b1) break;
    end
    check("tmo_latency", 64'(k), 64'd100);
    check("tmo_code", 64'(err_code), 64'd3);
    check("model_tmo_code", 64'(m_code), 64'd3);
    check("tmo_nwr", 64'(wlog.size()), 64'd0);
    send_byte(8'hA5, 0);
    check("tmo_clear", 64'(err), 64'd0);
    check("tmo_rebusy", 64'(busy), 64'd1);

    // Noise before sync, then lockout in RUN.
    do_reset();
    send_q(noise_f, noise_f.size(), 0, 1);
    check("noise_busy", 64'(busy), 64'd0);
    send_q(good_f, good_f.size(), 0, 1);
    check("noise_done", 64'(done), 64'd1);
    rf = make_frame(2, 32, 1'b0);
    send_q(rf, rf.size(), 0, 0);
    check("lock_nwr", 64'(wlog.size()), 64'd2);
    check("lock_busy", 64'(busy), 64'd0);
    check("lock_done", 64'(done), 64'd1);

    // Back-to-back bytes.
    do_reset();
    send_q(good_f, good_f.size(), 0, 0);
    check("b2b_nwr", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("b2b_w0", wlog[0], {18'd0, 14'h010, 32'hDEADBEEF});
      check("b2b_w1", wlog[1], {18'd0, 14'h011, 32'h01234567});
    end

    // Reset after two data bytes.
    do_reset();
    send_q(good_f, 7, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_addr", 64'(addr), 64'd0);
    check("mrst_wdata", 64'(wdata), 64'd0);
    check("mrst_core", 64'(core_rst_n), 64'd0);
    rst = 1'b0;
    send_q(good_f, good_f.size() - 7, 0, 0);
    idle(3);
    check("mrst_nwr", 64'(wlog.size()), 64'd0);

    // Randomized frame streams.
    for (int r = 0; r < 40; r++) begin
      do_reset();
      repeat ($urandom_range(5, 2)) begin
        kind = int'($urandom_range(5, 0));
        len  = int'($urandom_range(5, 1));
        base = int'($urandom_range((1 << ADDR_W) - len, 0));
        case (kind)
          0: begin rf = make_frame(len, base, 1'b0); send_q(rf, rf.size(), 0, 2); end
          1: begin rf = make_frame(len, base, 1'b1); send_q(rf, rf.size(), 0, 2); end
          2: begin
            case ($urandom_range(2, 0))
              0:       rf = '{8'hA5, 8'h00, 8'h00, 8'(base), 8'(base >> 8)};
              1: begin
                len = int'($urandom_range(300, 257));
                rf  = '{8'hA5, 8'(len), 8'(len >> 8), 8'h00, 8'h00};
              end
              default: begin
                base = int'($urandom_range(16'hFFFF, (1 << ADDR_W) - len + 1));
                rf   = '{8'hA5, 8'(len), 8'h00, 8'(base), 8'(base >> 8)};
              end
            endcase
            send_q(rf, rf.size(), 0, 2);
          end
          3: begin
            rf = make_frame(len, base, 1'b0);
            send_q(rf, int'($urandom_range(rf.size() - 1, 1)), 0, 2);
            idle(TMO + int'($urandom_range(5, 0)));
          end
          4: send_byte(8'($urandom), int'($urandom_range(3, 0)));
          default: begin
            rf = make_frame(len, base, 1'b0);
            send_q(rf, int'($urandom_range(rf.size() - 1, 1)), 0, 1);
            do_reset();
          end
        endcase
      end
      idle(2);
    end

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
